// File: rtl/hypot_sched.sv
// hypot_sched: round-robin sequencer sharing one sqrt(x^2+y^2) engine between two requesters.
// Optional zero-operand bypass enabled by defining HYPOT_SCHED_ZERO_BYPASS_EN.
module hypot_sched #(
    parameter int DW      = 8,
    parameter int RW      = 9,
    parameter int TIMEOUT = 63
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_x,
    input  logic [DW-1:0] req0_y,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_x,
    input  logic [DW-1:0] req1_y,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [RW-1:0] rsp0_data,
    output logic          rsp0_err,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [RW-1:0] rsp1_data,
    output logic          rsp1_err,
    output logic          eng_start,
    output logic [DW-1:0] eng_x,
    output logic [DW-1:0] eng_y,
    input  logic          eng_done,
    input  logic [RW-1:0] eng_result,
    output logic          busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic          gid_q, gid_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] data0_q, data0_d;
    logic [RW-1:0] data1_q, data1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    logic          grant_vld;
    logic          grant_id;
    logic          rsp_hs;
    logic          timed_out;
    logic [DW-1:0] gnt_x;
    logic [DW-1:0] gnt_y;

    // With both valid the pointer decides; with one valid that one wins.
    assign grant_vld = (state_q == IDLE) && ena && (req0_valid || req1_valid);
    assign grant_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign gnt_x     = grant_id ? req1_x : req0_x;
    assign gnt_y     = grant_id ? req1_y : req0_y;
    assign rsp_hs    = (state_q == RESP) && (gid_q ? rsp1_ready : rsp0_ready);
    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gid_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            timer_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            timer_q <= timer_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        x_d     = x_q;
        y_d     = y_q;
        timer_d = timer_q;
        data0_d = data0_q;
        data1_d = data1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    gid_d   = grant_id;
                    x_d     = gnt_x;
                    y_d     = gnt_y;
                    state_d = ISSUE;
`ifdef HYPOT_SCHED_ZERO_BYPASS_EN
                    // A zero leg makes the magnitude the other leg; skip the engine.
                    if ((gnt_x == '0) || (gnt_y == '0)) begin
                        state_d = RESP;
                        if (grant_id) begin
                            data1_d = RW'(gnt_x | gnt_y);
                            err1_d  = 1'b0;
                        end else begin
                            data0_d = RW'(gnt_x | gnt_y);
                            err0_d  = 1'b0;
                        end
                    end
`endif
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done || timed_out) begin
                    state_d = RESP;
                    if (gid_q) begin
                        data1_d = eng_done ? eng_result : '0;
                        err1_d  = !eng_done;
                    end else begin
                        data0_d = eng_done ? eng_result : '0;
                        err0_d  = !eng_done;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    rr_d    = !gid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant_vld && !grant_id;
        req1_ready = grant_vld && grant_id;
        eng_start  = (state_q == ISSUE);
        rsp0_valid = (state_q == RESP) && !gid_q;
        rsp1_valid = (state_q == RESP) && gid_q;
        busy       = (state_q != IDLE);
    end

    assign eng_x     = x_q;
    assign eng_y     = y_q;
    assign rsp0_data = data0_q;
    assign rsp1_data = data1_q;
    assign rsp0_err  = err0_q;
    assign rsp1_err  = err1_q;

endmodule

// File: tb/tb_hypot_sched.sv
// Directed self-checking bench for hypot_sched with a small delay-programmable engine model.
module tb_hypot_sched;

    localparam int DW = 8;
    localparam int RW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_x, req0_y, req1_x, req1_y;
    logic          rsp0_valid, rsp0_ready, rsp0_err;
    logic          rsp1_valid, rsp1_ready, rsp1_err;
    logic [RW-1:0] rsp0_data, rsp1_data;
    logic          eng_start, eng_done, busy;
    logic [DW-1:0] eng_x, eng_y;
    logic [RW-1:0] eng_result;

    int            checks = 0;
    int            errors = 0;
    int            starts = 0;
    int            s0;

    int            eng_dly = 1;
    int            eng_cnt = 0;
    logic          eng_en = 1'b1;
    logic          model_done = 1'b0;
    logic          stray = 1'b0;
    logic [RW-1:0] eng_res = '0;

    always #5 clk = ~clk;

    hypot_sched #(.DW(DW), .RW(RW), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
    );

    // Engine model: done pulses eng_dly cycles after the start cycle.
    always @(negedge clk) begin
        if (eng_start) begin
            eng_cnt    = eng_dly;
            model_done = 1'b0;
        end else if (eng_cnt != 0) begin
            eng_cnt    = eng_cnt - 1;
            model_done = (eng_cnt == 0) && eng_en;
        end else begin
            model_done = 1'b0;
        end
    end
    assign eng_done   = model_done | stray;
    assign eng_result = eng_res;

    always @(posedge clk) if (eng_start) starts <= starts + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input bit which, input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((which ? rsp1_valid : rsp0_valid) === 1'b1) break;
        end
        chk(tag, which ? rsp1_valid : rsp0_valid, 1);
    endtask

    task automatic hs(input bit which, input string tag);
        if (which) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk(tag, which ? rsp1_valid : rsp0_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_engx", eng_x, 0);
        chk("rst_rsp0v", rsp0_valid, 0);
        chk("rst_rsp1v", rsp1_valid, 0);
        chk("rst_rsp0d", rsp0_data, 0);
        rst = 1'b0;

        // Basic: (3,4) -> 5 with a 4-cycle engine
        @(negedge clk);
        eng_dly = 4; eng_res = 9'd5; eng_en = 1'b1;
        req0_valid = 1; req0_x = 3; req0_y = 4;
        #1;
        chk("basic_rdy0", req0_ready, 1);
        chk("basic_rdy1", req1_ready, 0);
        s0 = starts;
        @(negedge clk);
        req0_valid = 0;
        chk("basic_start", eng_start, 1);
        chk("basic_engx", eng_x, 3);
        chk("basic_engy", eng_y, 4);
        wait_rsp(0, "basic_valid");
        chk("basic_data", rsp0_data, 5);
        chk("basic_err", rsp0_err, 0);
        chk("basic_rsp1v", rsp1_valid, 0);
        chk("basic_nstart", starts - s0, 1);
        hs(0, "basic_hs");
        $display("txn basic data=%0d", 5);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Simultaneous requests, 1-cycle engine, then backpressure
        eng_dly = 1; eng_res = 9'd10;
        req0_valid = 1; req0_x = 6; req0_y = 8;
        req1_valid = 1; req1_x = 5; req1_y = 12;
        #1;
        chk("sim_rdy0", req0_ready, 1);
        chk("sim_rdy1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 0;
        chk("sim_start", eng_start, 1);
        chk("sim_engx", eng_x, 6);
        chk("sim_engy", eng_y, 8);
        chk("sim_rdy1_issue", req1_ready, 0);
        @(negedge clk);
        chk("lat_t2", rsp0_valid, 0);
        @(negedge clk);
        chk("lat_t3", rsp0_valid, 1);
        chk("sim_data0", rsp0_data, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp0_valid, 1);
            chk("bp_data", rsp0_data, 10);
            chk("bp_rdy1", req1_ready, 0);
        end
        rsp0_ready = 1;
        req0_valid = 1; req0_x = 6; req0_y = 8;
        eng_res = 9'd13;
        #1;
        chk("bp_rdy1_hs", req1_ready, 0);
        @(negedge clk);
        rsp0_ready = 0;
        chk("bp_drop", rsp0_valid, 0);
        chk("rr_rdy1", req1_ready, 1);
        chk("rr_rdy0", req0_ready, 0);
        @(negedge clk);
        req1_valid = 0;
        chk("rr_engx", eng_x, 5);
        chk("rr_engy", eng_y, 12);
        chk("rr_rdy0_busy", req0_ready, 0);
        wait_rsp(1, "sim_valid1");
        chk("sim_data1", rsp1_data, 13);
        chk("sim_err1", rsp1_err, 0);
        eng_res = 9'd10;
        hs(1, "sim_hs1");
        $display("txn simultaneous data1=%0d", 13);
        chk("rep_rdy0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        wait_rsp(0, "rep_valid0");
        chk("rep_data0", rsp0_data, 10);
        hs(0, "rep_hs0");

        // Timeout: engine never answers
        eng_en = 1'b0;
        req0_valid = 1; req0_x = 3; req0_y = 4;
        #1;
        chk("to_rdy0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        repeat (63) @(negedge clk);
        chk("to_early", rsp0_valid, 0);
        @(negedge clk);
        chk("to_valid", rsp0_valid, 1);
        chk("to_err", rsp0_err, 1);
        chk("to_data", rsp0_data, 0);
        stray = 1;
        @(negedge clk);
        stray = 0;
        chk("stray_err", rsp0_err, 1);
        chk("stray_data", rsp0_data, 0);
        hs(0, "to_hs");
        stray = 1;
        @(negedge clk);
        stray = 0;
        chk("stray_idle", busy, 0);
        eng_en = 1'b1; eng_res = 9'd13;
        req0_valid = 1; req0_x = 5; req0_y = 12;
        @(negedge clk);
        req0_valid = 0;
        wait_rsp(0, "after_to_valid");
        chk("after_to_data", rsp0_data, 13);
        chk("after_to_err", rsp0_err, 0);
        hs(0, "after_to_hs");
        $display("txn timeout then data=%0d", 13);

        // Reset while waiting on the engine
        eng_en = 1'b0;
        req1_valid = 1; req1_x = 8; req1_y = 15;
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        chk("rw_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_engx", eng_x, 0);
        chk("rw_engy", eng_y, 0);
        chk("rw_rsp1d", rsp1_data, 0);
        chk("rw_rsp0d", rsp0_data, 0);
        @(negedge clk);
        rst = 1'b0; eng_en = 1'b1;
        req0_valid = 1; req0_x = 1; req0_y = 1;
        req1_valid = 1; req1_x = 1; req1_y = 1;
        #1;
        chk("rw_ptr_rdy0", req0_ready, 1);
        chk("rw_ptr_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;

        // ena gating, then zero-operand request
        @(negedge clk);
        ena = 1'b0; eng_res = 9'h055;
        req0_valid = 1; req0_x = 0; req0_y = 7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ena_rdy0", req0_ready, 0);
            chk("ena_busy", busy, 0);
        end
        ena = 1'b1;
        #1;
        chk("ena_rdy0_on", req0_ready, 1);
        s0 = starts;
        @(negedge clk);
        req0_valid = 0;
`ifdef HYPOT_SCHED_ZERO_BYPASS_EN
        chk("byp_valid", rsp0_valid, 1);
        chk("byp_data", rsp0_data, 7);
        chk("byp_err", rsp0_err, 0);
        chk("byp_start", eng_start, 0);
        hs(0, "byp_hs");
        chk("byp_nstart", starts - s0, 0);
`else
        chk("nobyp_start", eng_start, 1);
        wait_rsp(0, "nobyp_valid");
        chk("nobyp_data", rsp0_data, 9'h055);
        chk("nobyp_err", rsp0_err, 0);
        hs(0, "nobyp_hs");
        chk("nobyp_nstart", starts - s0, 1);
`endif
        $display("txn zero-operand request done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
